// File: rtl/fetch_unit_if.sv
// Fetch-unit boundary: instruction-memory request/response, redirect, and decode-side handshake.
// master = fetch unit, slave = memory/decode environment.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_link;
  logic            misalign_fault;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_link, misalign_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_target, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_link, misalign_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_target, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Credit-limited in-order instruction fetch with redirect squash; responses reach decode one cycle after arrival.
// Requests stall when queued + in-flight reaches FIFO_DEPTH; responses are never back-pressured.
module fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;
  localparam logic [CW:0]     CREDIT_MAX = (CW+1)'(FIFO_DEPTH);
  localparam ptr_t            LAST_PTR   = ptr_t'(FIFO_DEPTH - 1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] BIT0_MASK  = ~XLEN'(1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d;
  cnt_t            count_q, count_d;
  cnt_t            outstanding_q, outstanding_d;
  cnt_t            drop_cnt_q, drop_cnt_d;
  ptr_t            rd_ptr_q, rd_ptr_d;
  ptr_t            wr_ptr_q, wr_ptr_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] mem_q [FIFO_DEPTH];
  logic [XLEN-1:0] mem_d [FIFO_DEPTH];

  logic [CW:0]     credit_sum;
  logic [XLEN-1:0] target;
  logic            req_vld, req_fire, inst_vld, pop, rsp, drop, push;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
  endfunction

  always_comb begin
    credit_sum = {1'b0, count_q} + {1'b0, outstanding_q};
    // Credit uses registered state only, keeping decode/memory inputs off the request path.
    req_vld    = !rst && !fault_q && (credit_sum < CREDIT_MAX);
    req_fire   = req_vld && bus.imem_req_ready;
    inst_vld   = (count_q != '0) && !fault_q;
    pop        = inst_vld && bus.inst_ready;
    rsp        = bus.imem_rsp_valid;
    drop       = rsp && (drop_cnt_q != '0);
    push       = rsp && !drop;
    target     = bus.redirect_target & BIT0_MASK;

    fetch_pc_d    = fetch_pc_q;
    head_pc_d     = head_pc_q;
    count_d       = count_q;
    drop_cnt_d    = drop_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fault_d       = fault_q;
    mem_d         = mem_q;
    outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(rsp);

    if (bus.redirect_valid) begin
      // Everything still in flight after this edge belongs to the wrong path.
      fetch_pc_d = target;
      head_pc_d  = target;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      drop_cnt_d = outstanding_d;
      fault_d    = target[1];
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (drop) drop_cnt_d = drop_cnt_q - cnt_t'(1);
      if (push) begin
        mem_d[wr_ptr_q] = bus.imem_rsp_data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d  = next_ptr(rd_ptr_q);
        head_pc_d = head_pc_q + PC_STEP;
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_VECTOR;
      head_pc_q     <= RESET_VECTOR;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fault_q       <= 1'b0;
      mem_q         <= '{default: '0};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      head_pc_q     <= head_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fault_q       <= fault_d;
      mem_q         <= mem_d;
    end
  end

  assign bus.imem_req_valid = req_vld;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = inst_vld;
  assign bus.inst_data      = mem_q[rd_ptr_q];
  assign bus.inst_pc        = head_pc_q;
  assign bus.inst_link      = head_pc_q + PC_STEP;
  assign bus.misalign_fault = fault_q;
endmodule
